// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and counter-width helper for the binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int IN_W_DEF   = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Counter must hold IN_W itself, so size it for IN_W+1 values.
  function automatic int cnt_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: d+3 when d>=5, otherwise d. Combinational, no state.
// No handshake: output follows input in the same cycle.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD (shift-and-add-3, one bit per clock); done/bcd IN_W edges after start.
// No backpressure: start is ignored while busy, bcd is held until the next completion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = cnt_w(IN_W);

  state_t                state;
  logic [IN_W-1:0]       bin_q;
  logic [4*DIGITS-1:0]   scr_q;
  logic [4*DIGITS-1:0]   scr_adj;
  logic [4*DIGITS-1:0]   scr_nxt;
  logic [CW-1:0]         cnt_q;

  // All digits are corrected in parallel before the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scr_q[4*i +: 4]),
      .q (scr_adj[4*i +: 4])
    );
  end

  // The binary MSB enters scratch bit 0; the top scratch bit never carries out for legal inputs.
  assign scr_nxt = (scr_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[IN_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= din;
            scr_q <= '0;
            cnt_q <= IN_W[CW-1:0];
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_nxt;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            bcd   <= scr_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed + random checks of bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] din   = '0;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int          vectors = 0;
  int          errors  = 0;
  logic [19:0] prev    = '0;

  always #5 clk = ~clk;

  bin2bcd_seq #(
    .IN_W   (16),
    .DIGITS (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge. Pulses start with v, then checks busy/done/bcd on every following cycle.
  // inj > 0 re-asserts start with inj_v during the run; it must be ignored.
  task automatic run_conv(input logic [15:0] v, input int inj, input logic [15:0] inj_v);
    logic [19:0] exp;
    exp   = to_bcd(v);
    din   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = 16'($urandom);
    check("accept_busy", busy, 1);
    check("accept_done", done, 0);
    check("accept_bcd", bcd, prev);
    for (int j = 1; j <= 16; j++) begin
      if (inj > 0 && j == inj) begin
        din   = inj_v;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      din   = 16'($urandom);
      check($sformatf("busy_c%0d_v%0d", j, v), busy, (j < 16) ? 1 : 0);
      check($sformatf("done_c%0d_v%0d", j, v), done, (j == 16) ? 1 : 0);
      check($sformatf("bcd_c%0d_v%0d", j, v), bcd, (j == 16) ? exp : prev);
    end
    prev = exp;
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bcd", bcd, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_bcd", bcd, 0);
    end

    // Basic and boundary values
    run_conv(16'd6, 0, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    run_conv(16'd315, 0, 0);
    @(negedge clk);
    run_conv(16'd0, 0, 0);
    @(negedge clk);
    run_conv(16'd65025, 0, 0);
    @(negedge clk);
    run_conv(16'd65535, 0, 0);
    @(negedge clk);
    run_conv(16'd255, 0, 0);
    @(negedge clk);

    // Start while busy is ignored, then back-to-back start in the done cycle
    run_conv(16'd1234, 5, 16'd9999);
    run_conv(16'd42, 0, 0);
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);

    // Reset mid-conversion
    din   = 16'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd, 0);
    prev = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("postrst_busy", busy, 0);
      check("postrst_done", done, 0);
      check("postrst_bcd", bcd, 0);
    end
    run_conv(16'd77, 0, 0);

    // Random values with random gaps (gap 0 means back-to-back)
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if (n % 4 == 3)
        run_conv(16'($urandom), $urandom_range(1, 15), 16'($urandom));
      else
        run_conv(16'($urandom), 0, 0);
    end

    @(negedge clk);
    check("final_done", done, 0);
    check("final_bcd", bcd, prev);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
